// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: 2^ADDR_W x DATA_W register file with
// write bypass, A/B source muxes, and the A/B operand latches feeding the ALU.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [15:0]       imm16,
  input  logic              asel,
  input  logic [1:0]        bsel,
  input  logic              ld,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              ab_valid,
  output logic [DATA_W-1:0] rt_data
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] CONST4 = DATA_W'(4);

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] x);
    logic signed [15:0]       sx;
    logic signed [DATA_W-1:0] ext;
    sx  = signed'(x);
    ext = {{(DATA_W-16){sx[15]}}, sx};
    return ext;
  endfunction

  function automatic logic [DATA_W-1:0] zero_ext16(input logic [15:0] x);
    return {{(DATA_W-16){1'b0}}, x};
  endfunction

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;
  logic [DATA_W-1:0] rs_data_p0;
  logic [DATA_W-1:0] rt_data_p0;
  logic [DATA_W-1:0] a_mux_p0;
  logic [DATA_W-1:0] b_mux_p0;

  // Address 0 is never written, so it stays at its reset value of zero.
  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Stage p0: combinational reads with same-cycle write bypass, source muxes
  always_comb begin
    rs_data_p0 = regs[rs_addr];
    if (wr_en && (wa == rs_addr)) rs_data_p0 = wd;
    if (rs_addr == '0)            rs_data_p0 = '0;

    rt_data_p0 = regs[rt_addr];
    if (wr_en && (wa == rt_addr)) rt_data_p0 = wd;
    if (rt_addr == '0)            rt_data_p0 = '0;

    a_mux_p0 = asel ? pc : rs_data_p0;

    b_mux_p0 = rt_data_p0;
    case (bsel)
      2'b00:   b_mux_p0 = rt_data_p0;
      2'b01:   b_mux_p0 = sign_ext16(imm16);
      2'b10:   b_mux_p0 = zero_ext16(imm16);
      default: b_mux_p0 = CONST4;
    endcase
  end

  assign rt_data = rt_data_p0;

  // Stage p1: operand latches, held while ld is low so the ALU result stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A        <= '0;
      B        <= '0;
      ab_valid <= 1'b0;
    end else if (ld) begin
      A        <= a_mux_p0;
      B        <= b_mux_p0;
      ab_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed vectors with hand-computed
// expectations, then a random run against a reference register model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wa;
  logic [31:0] pc, wd;
  logic [15:0] imm16;
  logic        asel, ld, we;
  logic [1:0]  bsel;
  logic [31:0] A, B, rt_data;
  logic        ab_valid;

  alu_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .pc(pc),
    .imm16(imm16), .asel(asel), .bsel(bsel), .ld(ld), .we(we), .wa(wa),
    .wd(wd), .A(A), .B(B), .ab_valid(ab_valid), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ca;
    logic [31:0] a;
    logic        cb;
    logic [31:0] b;
    logic        crt;
    logic [31:0] rt;
    logic        v;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        me;
  logic [31:0] rt_smp;
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t mk(input logic ca, input logic [31:0] a,
                              input logic cb, input logic [31:0] b,
                              input logic crt, input logic [31:0] rt,
                              input logic v);
    exp_t e;
    e.ca = ca; e.a = a; e.cb = cb; e.b = b; e.crt = crt; e.rt = rt; e.v = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // rt_data is captured just before the edge that consumes the cycle's inputs
  always @(posedge clk) rt_smp = rt_data;

  // Monitor: each negedge the outputs reflect the previous issued cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      me = sb_q.pop_front();
      if (me.ca)  chk("A", A, me.a);
      if (me.cb)  chk("B", B, me.b);
      if (me.crt) chk("rt_data", rt_smp, me.rt);
      chk("ab_valid", {31'b0, ab_valid}, {31'b0, me.v});
    end
  end

  task automatic vec(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] pcv, input logic [15:0] imm,
                     input logic as, input logic [1:0] bs, input logic l,
                     input logic w, input logic [4:0] waddr, input logic [31:0] wdat,
                     input exp_t e);
    @(negedge clk);
    rst = r; rs_addr = rs; rt_addr = rt; pc = pcv; imm16 = imm;
    asel = as; bsel = bs; ld = l; we = w; wa = waddr; wd = wdat;
    #1;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [31:0] mregs [32];
    logic [31:0] a_m, b_m, rs_v, rt_v, ea, eb;
    logic        v_m;
    logic [4:0]  r_rs, r_rt, r_wa;
    logic [31:0] r_pc, r_wd;
    logic [15:0] r_imm;
    logic        r_as, r_ld, r_we;
    logic [1:0]  r_bs;

    rst = 1'b1; rs_addr = '0; rt_addr = '0; pc = '0; imm16 = '0;
    asel = 1'b0; bsel = 2'b00; ld = 1'b0; we = 1'b0; wa = '0; wd = '0;
    repeat (2) @(negedge clk);

    // Reset state and every register reads zero
    for (int i = 0; i < 32; i++)
      vec(1'b0, 5'd0, 5'(i), 32'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(1, 32'h0, 1, 32'h0, 1, 32'h0, 0));

    // Write reg5, attempt reg0, then read both back through A/B
    vec(0, 5'd0, 5'd5, 32'h0, 16'h0, 0, 2'b00, 0, 1, 5'd5, 32'hDEAD_BEEF,
        mk(1, 32'h0, 1, 32'h0, 1, 32'hDEAD_BEEF, 0));
    vec(0, 5'd0, 5'd0, 32'h0, 16'h0, 0, 2'b00, 0, 1, 5'd0, 32'h1234_5678,
        mk(1, 32'h0, 1, 32'h0, 1, 32'h0, 0));
    vec(0, 5'd5, 5'd0, 32'h0, 16'h0, 0, 2'b11, 1, 0, 5'd0, 32'h0,
        mk(1, 32'hDEAD_BEEF, 1, 32'h4, 1, 32'h0, 1));
    vec(0, 5'd0, 5'd5, 32'h0, 16'h0, 0, 2'b00, 1, 0, 5'd0, 32'h0,
        mk(1, 32'h0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1));

    // Same-cycle bypass on both ports while latching
    vec(0, 5'd7, 5'd7, 32'h0, 16'h0, 0, 2'b00, 1, 1, 5'd7, 32'hA5A5_A5A5,
        mk(1, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 1));

    // B-source variants and PC on A
    vec(0, 5'd0, 5'd7, 32'h0000_0040, 16'h8001, 1, 2'b01, 1, 0, 5'd0, 32'h0,
        mk(1, 32'h0000_0040, 1, 32'hFFFF_8001, 1, 32'hA5A5_A5A5, 1));
    vec(0, 5'd0, 5'd0, 32'h0000_0040, 16'h8001, 1, 2'b10, 1, 0, 5'd0, 32'h0,
        mk(1, 32'h0000_0040, 1, 32'h0000_8001, 1, 32'h0, 1));
    vec(0, 5'd0, 5'd0, 32'h0000_0040, 16'h8001, 1, 2'b11, 1, 0, 5'd0, 32'h0,
        mk(1, 32'h0000_0040, 1, 32'h0000_0004, 1, 32'h0, 1));

    // Hold: latch A=3, B=9, then churn every input with ld low
    vec(0, 5'd0, 5'd0, 32'h0, 16'h0, 0, 2'b00, 0, 1, 5'd3, 32'd3,
        mk(1, 32'h40, 1, 32'h4, 0, 32'h0, 1));
    vec(0, 5'd0, 5'd0, 32'h0, 16'h0, 0, 2'b00, 0, 1, 5'd9, 32'd9,
        mk(1, 32'h40, 1, 32'h4, 0, 32'h0, 1));
    vec(0, 5'd3, 5'd9, 32'h0, 16'h0, 0, 2'b00, 1, 0, 5'd0, 32'h0,
        mk(1, 32'd3, 1, 32'd9, 1, 32'd9, 1));
    for (int k = 1; k <= 5; k++)
      vec(0, 5'(k), 5'd3, 32'(k * 8), 16'(k), k[0], 2'(k), 0, 1, 5'd3,
          32'h1111_1111 * 32'(k),
          mk(1, 32'd3, 1, 32'd9, 1, 32'h1111_1111 * 32'(k), 1));
    vec(0, 5'd0, 5'd3, 32'h0, 16'h0, 0, 2'b00, 0, 0, 5'd0, 32'h0,
        mk(1, 32'd3, 1, 32'd9, 1, 32'h5555_5555, 1));

    // Asynchronous reset mid-run: outputs clear without a clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_A", A, 32'h0);
    chk("async_rst_B", B, 32'h0);
    chk("async_rst_ab_valid", {31'b0, ab_valid}, 32'h0);
    vec(1, 5'd3, 5'd3, 32'h0, 16'h0, 0, 2'b00, 1, 1, 5'd3, 32'hFFFF_0000,
        mk(1, 32'h0, 1, 32'h0, 0, 32'h0, 0));
    for (int i = 0; i < 32; i++)
      vec(0, 5'd0, 5'(i), 32'h0, 16'h0, 0, 2'b00, 0, 0, 5'd0, 32'h0,
          mk(1, 32'h0, 1, 32'h0, 1, 32'h0, 0));

    // Random regression against a reference register file
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    a_m = '0; b_m = '0; v_m = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      r_rs  = 5'($urandom_range(0, 7));
      r_rt  = 5'($urandom_range(0, 7));
      r_wa  = 5'($urandom_range(0, 7));
      r_pc  = $urandom;
      r_wd  = $urandom;
      r_imm = 16'($urandom);
      r_as  = 1'($urandom);
      r_bs  = 2'($urandom);
      r_ld  = ($urandom_range(0, 1) == 1);
      r_we  = ($urandom_range(0, 3) != 0);
      rs_v = (r_we && r_wa != 0 && r_wa == r_rs) ? r_wd : mregs[r_rs];
      rt_v = (r_we && r_wa != 0 && r_wa == r_rt) ? r_wd : mregs[r_rt];
      ea = r_as ? r_pc : rs_v;
      case (r_bs)
        2'b00:   eb = rt_v;
        2'b01:   eb = {{16{r_imm[15]}}, r_imm};
        2'b10:   eb = {16'h0, r_imm};
        default: eb = 32'd4;
      endcase
      if (r_ld) begin a_m = ea; b_m = eb; v_m = 1'b1; end
      if (r_we && r_wa != 0) mregs[r_wa] = r_wd;
      vec(0, r_rs, r_rt, r_pc, r_imm, r_as, r_bs, r_ld, r_we, r_wa, r_wd,
          mk(1, a_m, 1, b_m, 1, rt_v, v_m));
    end

    // Drain: every issued cycle must have been consumed by the monitor
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
